// File: rtl/ones_stat_pkg.sv
// ones_stat_pkg: shared types and constants for the ones statistics accumulator
package ones_stat_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;
  localparam int ONES_W = 6;
  localparam logic [ONES_W-1:0] MIN_INIT = 6'd63;
  localparam int HALF_BOUND = 16;
  localparam int FULL_BOUND = 32;
endpackage

// File: rtl/ones_stat_accum.sv
// ones_stat_accum: per-frame total/max/min/count statistics over a stream of popcounts
module ones_stat_accum
  import ones_stat_pkg::*;
#(
  parameter int WORDS_PER_FRAME = 8,
  parameter int TOTAL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ONES_W-1:0]  ones_in,
  input  logic               in_size,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TOTAL_W-1:0] out_total,
  output logic [ONES_W-1:0]  out_max,
  output logic [ONES_W-1:0]  out_min,
  output logic [7:0]         out_words,
  output logic               out_sat,
  output logic               out_err
);
  state_t state, state_n;
  logic [TOTAL_W-1:0] total, total_n;
  logic [TOTAL_W:0] sum;
  logic [ONES_W-1:0] max_v, max_n, min_v, min_n;
  logic [7:0] words, words_n;
  logic sat, sat_n, err, err_n, acc, bad, close;
  assign in_ready = state != REPORT;
  assign out_valid = state == REPORT;
  assign acc = in_valid && in_ready;
  always_comb begin
    sum = {1'b0, total} + (TOTAL_W+1)'(ones_in);
    bad = in_size ? ones_in > ONES_W'(FULL_BOUND) : ones_in > ONES_W'(HALF_BOUND);
    total_n = !acc ? total : sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
    sat_n = sat || (acc && sum[TOTAL_W]);
    err_n = err || (acc && bad);
    max_n = (acc && ones_in > max_v) ? ones_in : max_v;
    min_n = (acc && ones_in < min_v) ? ones_in : min_v;
    words_n = words + 8'(acc);
    close = in_ready && ((acc && words_n == 8'(WORDS_PER_FRAME)) || (flush && words_n != '0));
    state_n = close ? REPORT : (state == REPORT) ? (out_ready ? IDLE : REPORT) : acc ? ACCUM : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      total <= '0;
      max_v <= '0;
      min_v <= MIN_INIT;
      words <= '0;
      sat <= 1'b0;
      err <= 1'b0;
      out_total <= '0;
      out_max <= '0;
      out_min <= '0;
      out_words <= '0;
      out_sat <= 1'b0;
      out_err <= 1'b0;
    end else begin
      state <= state_n;
      if (out_valid && out_ready) begin
        total <= '0;
        max_v <= '0;
        min_v <= MIN_INIT;
        words <= '0;
        sat <= 1'b0;
        err <= 1'b0;
      end else begin
        total <= total_n;
        max_v <= max_n;
        min_v <= min_n;
        words <= words_n;
        sat <= sat_n;
        err <= err_n;
      end
      if (close) begin
        out_total <= total_n;
        out_max <= max_n;
        out_min <= min_n;
        out_words <= words_n;
        out_sat <= sat_n;
        out_err <= err_n;
      end
    end
  end
endmodule

// File: tb/tb_ones_stat_accum.sv
// tb_ones_stat_accum: scoreboard bench with a frame-list reference model
module tb_ones_stat_accum;
  localparam int WPF = 8;
  localparam int TMAX = 65535;
  typedef struct {int total; int mx; int mn; int words; int sat; int err;} rep_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_size = 1'b1, flush = 1'b0, out_ready = 1'b1;
  logic [5:0] ones_in = '0;
  logic in_ready, out_valid, out_sat, out_err;
  logic [15:0] out_total;
  logic [5:0] out_max, out_min;
  logic [7:0] out_words;
  logic v6 = 1'b0, s6 = 1'b1, f6 = 1'b0, o6 = 1'b1;
  logic [5:0] d6 = '0;
  logic ready6, ov6, sat6, err6;
  logic [5:0] tot6, max6, min6;
  logic [7:0] words6;
  int tests = 0, fails = 0;
  int frame[$];
  bit frame_bad[$];
  bit m_rep = 0;
  rep_t sb[$];
  always #5 clk = ~clk;
  ones_stat_accum dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ones_in(ones_in),
    .in_size(in_size), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_total(out_total), .out_max(out_max), .out_min(out_min), .out_words(out_words),
    .out_sat(out_sat), .out_err(out_err)
  );
  ones_stat_accum #(.WORDS_PER_FRAME(2), .TOTAL_W(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(v6), .in_ready(ready6), .ones_in(d6),
    .in_size(s6), .flush(f6), .out_valid(ov6), .out_ready(o6),
    .out_total(tot6), .out_max(max6), .out_min(min6), .out_words(words6),
    .out_sat(sat6), .out_err(err6)
  );
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic rep_t summarize();
    rep_t r;
    int s = 0;
    r.mx = 0;
    r.mn = 63;
    r.err = 0;
    foreach (frame[i]) begin
      s += frame[i];
      if (frame[i] > r.mx) r.mx = frame[i];
      if (frame[i] < r.mn) r.mn = frame[i];
      if (frame_bad[i]) r.err = 1;
    end
    r.sat = s > TMAX;
    r.total = r.sat ? TMAX : s;
    r.words = frame.size();
    return r;
  endfunction
  task automatic step(input bit v, input int w, input bit s, input bit f, input bit o, input bit r);
    in_valid = v;
    ones_in = 6'(w);
    in_size = s;
    flush = f;
    out_ready = o;
    rst = r;
    chk("in_ready", in_ready, !m_rep);
    chk("out_valid", out_valid, m_rep);
    if (r) begin
      frame.delete();
      frame_bad.delete();
      sb.delete();
      m_rep = 0;
    end else if (m_rep) begin
      if (o) m_rep = 0;
    end else begin
      if (v) begin
        frame.push_back(w);
        frame_bad.push_back(s ? w > 32 : w > 16);
      end
      if ((v && frame.size() == WPF) || (f && frame.size() > 0)) begin
        sb.push_back(summarize());
        frame.delete();
        frame_bad.delete();
        m_rep = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n, input bit o);
    repeat (n) step(0, 0, 1, 0, o, 0);
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_report actual total=%0d required none", out_total);
      end else begin
        chk("out_total", out_total, sb[0].total);
        chk("out_max", out_max, sb[0].mx);
        chk("out_min", out_min, sb[0].mn);
        chk("out_words", out_words, sb[0].words);
        chk("out_sat", out_sat, sb[0].sat);
        chk("out_err", out_err, sb[0].err);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end
  initial begin
    int t1[8] = '{3, 0, 16, 32, 5, 5, 1, 7};
    int t2[3] = '{4, 9, 2};
    @(posedge clk);
    #1;
    step(0, 0, 1, 0, 1, 1);
    step(0, 0, 1, 0, 1, 1);
    step(0, 0, 1, 0, 1, 0);
    chk("rst_total", out_total, 0);
    chk("rst_max", out_max, 0);
    chk("rst_min", out_min, 0);
    chk("rst_words", out_words, 0);
    chk("rst_flags", {out_sat, out_err}, 0);
    foreach (t1[i]) step(1, t1[i], 1, 0, 1, 0);
    idle(2, 1);
    foreach (t2[i]) step(1, t2[i], 1, 0, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    idle(2, 1);
    foreach (t2[i]) step(1, t2[i], 1, 0, 1, 0);
    step(1, 11, 1, 1, 1, 0);
    idle(2, 1);
    for (int i = 0; i < 8; i++) step(1, i + 10, 1, 0, 0, 0);
    repeat (5) step(1, 5, 1, 1, 0, 0);
    step(1, 5, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    idle(1, 1);
    step(1, 20, 0, 1, 1, 0);
    idle(2, 1);
    step(1, 20, 1, 1, 1, 0);
    idle(2, 1);
    step(1, 33, 1, 1, 1, 0);
    idle(2, 1);
    for (int i = 0; i < 5; i++) step(1, 30, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 1);
    step(0, 0, 1, 0, 1, 0);
    chk("rst2_total", out_total, 0);
    chk("rst2_words", out_words, 0);
    step(0, 0, 1, 1, 1, 0);
    idle(2, 1);
    step(1, 2, 1, 0, 1, 0);
    step(1, 6, 1, 1, 1, 0);
    idle(2, 1);
    for (int i = 0; i < 600; i++) begin
      bit s = 1'($urandom_range(0, 1));
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, s ? 36 : 20)), s,
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    end
    idle(3, 1);
    chk("sb_drained", sb.size(), 0);
    for (int k = 0; k < 4; k++) begin
      int a = (k == 0) ? 32 : int'($urandom_range(10, 32));
      int b = (k == 0) ? 32 : int'($urandom_range(10, 32));
      int n = 0;
      v6 = 1'b1;
      d6 = 6'(a);
      @(posedge clk);
      #1;
      d6 = 6'(b);
      @(posedge clk);
      #1;
      v6 = 1'b0;
      while (!ov6 && n < 4) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("sat6_latency", n, 0);
      chk("sat6_valid", ov6, 1);
      chk("sat6_total", tot6, (a + b > 63) ? 63 : a + b);
      chk("sat6_sat", sat6, a + b > 63);
      chk("sat6_max", max6, (a > b) ? a : b);
      chk("sat6_min", min6, (a < b) ? a : b);
      chk("sat6_words", words6, 2);
      @(posedge clk);
      #1;
      chk("sat6_ready", ready6, 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
